// File: rtl/growing_avg_signed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : growing_avg_signed_pkg
//  Description : Shared defaults and helpers for the signed block averager.
//  Revision    : 1.0 - initial release
// ============================================================================
package growing_avg_signed_pkg;

  localparam int c_n_default        = 16;
  localparam int c_max_log2_default = 8;

  // Limit the requested log2 window length to what the accumulator supports.
  function automatic logic [7:0] clamp_log2(input logic [7:0] req,
                                            input logic [7:0] limit);
    return (req > limit) ? limit : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/growing_avg_signed_acc.sv
`default_nettype none
// ============================================================================
//  Module      : growing_avg_signed_acc
//  Description : Signed accumulator with sign-extended add and clear-on-add.
//                The combinational sum (acc + x) is exported so the parent can
//                form the window result on the same edge that closes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module growing_avg_signed_acc #(
  parameter int N     = 16,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic signed [N-1:0]     x,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_x_ext;

  assign w_x_ext = {{(ACC_W-N){x[N-1]}}, x};
  assign sum     = r_acc + w_x_ext;

  // Accumulate accepted samples; a closing sample restarts the sum at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= clear ? '0 : sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/growing_avg_signed.sv
`default_nettype none
// ============================================================================
//  Module      : growing_avg_signed
//  Description : Streaming block averager. Sums 2^n valid signed samples, then
//                emits floor(mean) with a one-cycle new_dat strobe and restarts
//                with a fresh, non-overlapping window.
//  Revision    : 1.0 - initial release
// ============================================================================
module growing_avg_signed
  import growing_avg_signed_pkg::*;
#(
  parameter int N        = c_n_default,
  parameter int MAX_LOG2 = c_max_log2_default
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic signed [N-1:0] x,
  input  logic [7:0]          N_AVGS_in,
  output logic                new_dat,
  output logic signed [N-1:0] y
);

  localparam int ACC_W = N + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [CNT_W-1:0]        r_cnt;
  logic [7:0]              r_n_lat;
  logic signed [N-1:0]     r_y;
  logic                    r_new;

  logic [7:0]              w_n_req;
  logic [7:0]              w_n_cur;
  logic                    w_first;
  logic                    w_last;
  logic [CNT_W-1:0]        w_target;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [N-1:0]     w_mean;

  // The first sample of a window uses the live request; later samples use the
  // length captured with that first sample, so mid-window changes wait.
  assign w_n_req  = clamp_log2(N_AVGS_in, 8'(MAX_LOG2));
  assign w_first  = (r_cnt == '0);
  assign w_n_cur  = w_first ? w_n_req : r_n_lat;
  assign w_target = c_cnt_one << w_n_cur;
  assign w_last   = (r_cnt == (w_target - c_cnt_one));

  // Arithmetic shift floors toward -inf; the mean of N-bit values fits in N bits.
  assign w_mean   = N'(w_sum >>> w_n_cur);

  growing_avg_signed_acc #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (valid),
    .clear (w_last),
    .x     (x),
    .sum   (w_sum)
  );

  // Window bookkeeping, registered result and completion strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_n_lat <= '0;
      r_y     <= '0;
      r_new   <= 1'b0;
    end else begin
      r_new <= valid && w_last;
      if (valid) begin
        if (w_first) begin
          r_n_lat <= w_n_req;
        end
        r_cnt <= w_last ? '0 : (r_cnt + c_cnt_one);
        if (w_last) begin
          r_y <= w_mean;
        end
      end
    end
  end

  assign new_dat = r_new;
  assign y       = r_y;

endmodule
`default_nettype wire

// File: tb/tb_growing_avg_signed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_growing_avg_signed
//  Description : Scoreboard bench for growing_avg_signed. The driver pushes the
//                expected average when it issues the closing sample of a window;
//                a monitor pops and compares on every new_dat strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_growing_avg_signed;

  logic               clk;
  logic               rst_n;
  logic               valid;
  logic signed [15:0] x;
  logic [7:0]         N_AVGS_in;
  logic               new_dat;
  logic signed [15:0] y;

  int checks;
  int errors;
  int pulses;

  logic signed [15:0] exp_q[$];

  // Reference window state kept by the bench
  longint m_sum;
  int     m_cnt;
  int     m_n;

  growing_avg_signed #(.N(16), .MAX_LOG2(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .x         (x),
    .N_AVGS_in (N_AVGS_in),
    .new_dat   (new_dat),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest expected average
  always @(negedge clk) begin
    if (rst_n && new_dat) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_new_dat: got y=%0d expected no strobe", y);
      end else begin
        logic signed [15:0] e;
        e = exp_q.pop_front();
        if (y !== e) begin
          errors++;
          $display("FAIL window_avg: got y=%0d expected %0d", y, e);
        end
      end
    end
  end

  // Issue one valid sample (called aligned to a negedge), then idle for gap cycles
  task automatic send(input logic signed [15:0] v, input int gap);
    if (m_cnt == 0) m_n = (N_AVGS_in > 8) ? 8 : int'(N_AVGS_in);
    m_sum += longint'(v);
    m_cnt++;
    if (m_cnt == (1 << m_n)) begin
      exp_q.push_back(16'(m_sum >>> m_n));
      m_sum = 0;
      m_cnt = 0;
    end
    valid = 1'b1;
    x     = v;
    @(negedge clk);
    valid = 1'b0;
    x     = 16'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("reset_y", y, 0);
    check("reset_new_dat", new_dat, 0);
    rst_n = 1'b1;
    m_sum = 0;
    m_cnt = 0;
  endtask

  // Let the last result drain, then check the strobe count for the phase
  task automatic end_phase(input string name, input int want);
    repeat (3) @(negedge clk);
    check(name, pulses, want);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    pulses = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulses    = 0;
    m_sum     = 0;
    m_cnt     = 0;
    m_n       = 0;
    rst_n     = 1'b0;
    valid     = 1'b0;
    x         = '0;
    N_AVGS_in = 8'd1;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic window of 2
    N_AVGS_in = 8'd1;
    send(16'sd0, 0);  send(16'sd10, 0);
    @(negedge clk);
    check("basic_y_5", y, 5);
    send(16'sd20, 0); send(16'sd20, 0);
    @(negedge clk);
    check("basic_y_20", y, 20);
    end_phase("basic_pulses", 2);

    // Negative floor rounding
    send(-16'sd3, 0); send(-16'sd4, 0);
    @(negedge clk);
    check("floor_y_m4", y, -4);
    send(-16'sd1, 0); send(16'sd0, 0);
    @(negedge clk);
    check("floor_y_m1", y, -1);
    end_phase("floor_pulses", 2);

    // Gapped valid, window of 4
    N_AVGS_in = 8'd2;
    for (int i = 1; i <= 4; i++) send(16'(4 * i - 512), 2);
    check("gap_y_m502", y, -502);
    end_phase("gap_pulses_a", 1);
    for (int i = 5; i <= 8; i++) send(16'(4 * i - 512), 2);
    repeat (5) @(negedge clk);
    check("gap_y_hold_m486", y, -486);
    end_phase("gap_pulses_b", 1);

    // Length sweep over a ramp
    for (int k = 1; k <= 7; k++) begin
      do_reset();
      N_AVGS_in = 8'(k);
      for (int i = 1; i <= 1023; i++) send(16'(4 * i - 512), 0);
      end_phase($sformatf("sweep_pulses_k%0d", k), 1023 >> k);
    end

    // Mid-window length change: current window keeps length 4
    do_reset();
    N_AVGS_in = 8'd2;
    send(16'sd1, 0); send(16'sd2, 0);
    N_AVGS_in = 8'd1;
    send(16'sd3, 0); send(16'sd4, 0);
    @(negedge clk);
    check("len_change_y_2", y, 2);
    send(16'sd7, 0); send(16'sd8, 0);
    @(negedge clk);
    check("len_change_next_y_7", y, 7);
    end_phase("len_change_pulses", 2);

    // Reset mid-window discards the partial sum
    N_AVGS_in = 8'd2;
    send(16'sd100, 0); send(16'sd100, 0);
    do_reset();
    send(16'sd8, 0); send(16'sd8, 0); send(16'sd8, 0); send(16'sd9, 0);
    @(negedge clk);
    check("post_reset_y_8", y, 8);
    end_phase("post_reset_pulses", 1);

    // Extremes at the longest window, plus clamping of oversize requests
    N_AVGS_in = 8'd8;
    for (int i = 0; i < 256; i++) send(16'sh8000, 0);
    @(negedge clk);
    check("extreme_min", y, -32768);
    N_AVGS_in = 8'd12;
    for (int i = 0; i < 256; i++) send(16'sh7FFF, 0);
    @(negedge clk);
    check("extreme_max_clamped", y, 32767);
    end_phase("extreme_pulses", 2);

    // Window of 1: y follows x one cycle later
    N_AVGS_in = 8'd0;
    send(16'sd5, 0);
    check("n0_y_5", y, 5);
    check("n0_strobe", new_dat, 1);
    send(-16'sd7, 1);
    check("n0_strobe_low", new_dat, 0);
    send(16'sh7FFF, 0);
    check("n0_y_max", y, 32767);
    end_phase("n0_pulses", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
